// File: rtl/instr_loader.sv
// Byte-stream program loader for the autoencoder core's instruction memory.
// Packs byte pairs into 16-bit words, verifies a trailing XOR checksum, then releases the core.
module instr_loader #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DEPTH      = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [15:0]           wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  core_run
);

  // One extra bit so a full-depth load (length 0) is representable.
  localparam int unsigned CntW = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    StIdle,
    StHi,
    StLo,
    StCheck,
    StRun,
    StErr
  } state_e;

  state_e                r_state, w_state_d;
  logic [CntW-1:0]       r_count, w_count_d;
  logic [ADDR_WIDTH-1:0] r_index, w_index_d;
  logic [7:0]            r_csum, w_csum_d;
  logic [7:0]            r_hi, w_hi_d;
  logic                  r_wr_en, w_wr_en_d;
  logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr_d;
  logic [15:0]           r_wr_data, w_wr_data_d;
  logic                  r_done, w_done_d;

  logic                  w_busy;
  logic                  w_xfer;
  logic                  w_last;
  logic [CntW-1:0]       w_len_words;

  assign w_busy      = (r_state == StHi) || (r_state == StLo) || (r_state == StCheck);
  assign w_xfer      = in_valid & w_busy;
  assign w_last      = (({1'b0, r_index} + CntW'(1)) == r_count);
  assign w_len_words = (length == '0) ? CntW'(DEPTH) : {1'b0, length};

  always_comb begin
    w_state_d   = r_state;
    w_count_d   = r_count;
    w_index_d   = r_index;
    w_csum_d    = r_csum;
    w_hi_d      = r_hi;
    w_wr_en_d   = 1'b0;
    w_wr_addr_d = r_wr_addr;
    w_wr_data_d = r_wr_data;
    w_done_d    = 1'b0;

    unique case (r_state)
      StIdle, StRun, StErr: begin
        if (start) begin
          w_state_d = StHi;
          w_count_d = w_len_words;
          w_index_d = '0;
          w_csum_d  = 8'h00;
        end
      end
      StHi: begin
        if (w_xfer) begin
          w_hi_d    = in_data;
          w_csum_d  = r_csum ^ in_data;
          w_state_d = StLo;
        end
      end
      StLo: begin
        if (w_xfer) begin
          w_csum_d    = r_csum ^ in_data;
          w_wr_en_d   = 1'b1;
          w_wr_addr_d = r_index;
          w_wr_data_d = {r_hi, in_data};
          w_index_d   = r_index + 1'b1;
          w_state_d   = w_last ? StCheck : StHi;
        end
      end
      StCheck: begin
        if (w_xfer) begin
          if (in_data == r_csum) begin
            w_state_d = StRun;
            w_done_d  = 1'b1;
          end else begin
            w_state_d = StErr;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_count   <= '0;
      r_index   <= '0;
      r_csum    <= 8'h00;
      r_hi      <= 8'h00;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= 16'h0000;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_count   <= w_count_d;
      r_index   <= w_index_d;
      r_csum    <= w_csum_d;
      r_hi      <= w_hi_d;
      r_wr_en   <= w_wr_en_d;
      r_wr_addr <= w_wr_addr_d;
      r_wr_data <= w_wr_data_d;
      r_done    <= w_done_d;
    end
  end

  // Ready depends on state alone so upstream can never form a valid/ready loop.
  assign in_ready = w_busy;
  assign busy     = w_busy;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign done     = r_done;
  assign error    = (r_state == StErr);
  assign core_run = (r_state == StRun);

endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader: drives byte streams with optional gaps and compares the
// observed memory writes and status against a word-list/checksum reference model.
module tb_instr_loader;

  localparam int AW = 5;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] length = '0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          busy;
  logic          done;
  logic          error;
  logic          core_run;

  always #5 clock = ~clock;

  instr_loader #(
    .ADDR_WIDTH(AW),
    .DEPTH     (32)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .length  (length),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .core_run(core_run)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write/done observer, sampled on the falling edge.
  int            cyc = 0;
  logic [AW-1:0] q_addr[$];
  logic [15:0]   q_data[$];
  int            q_cyc[$];
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            b2b_cnt = 0;
  int            rdy_viol = 0;
  logic          prev_wr = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset_n) begin
      if (wr_en) begin
        q_addr.push_back(wr_addr);
        q_data.push_back(wr_data);
        q_cyc.push_back(cyc);
        if (prev_wr) b2b_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (in_ready !== busy) rdy_viol++;
      prev_wr = wr_en;
    end else begin
      prev_wr = 1'b0;
    end
  end

  logic [15:0] stim_w[$];

  task automatic do_start(input logic [AW-1:0] len);
    in_valid = 1'b0;
    start    = 1'b1;
    length   = len;
    @(negedge clock);
    start    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int gap;
    int k;
    gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    repeat (gap) begin
      in_valid = 1'b0;
      @(negedge clock);
    end
    in_valid = 1'b1;
    in_data  = b;
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clock);
      k++;
    end
    if (!in_ready) check_eq("ready_timeout", 32'd0, 32'd1);
    @(negedge clock);
  endtask

  // Loads stim_w[0..nwords-1]; the model is the word list itself plus the XOR of its bytes.
  task automatic run_load(input string tag, input int nwords, input bit bad,
                          input logic [7:0] bad_byte, input int maxgap, input int inj_word,
                          input bit timing);
    logic [7:0]  cs;
    logic [7:0]  sent;
    logic [15:0] w;
    bit          good;
    int          s_cyc;
    int          nspace;
    cs = 8'h00;
    for (int i = 0; i < nwords; i++) begin
      w  = stim_w[i];
      cs = cs ^ w[15:8] ^ w[7:0];
    end
    sent = bad ? bad_byte : cs;
    good = (sent == cs);

    q_addr.delete();
    q_data.delete();
    q_cyc.delete();
    done_cnt = 0;

    do_start(nwords[AW-1:0]);
    s_cyc = cyc;
    check_eq({tag, "_busy_after_start"}, busy, 1);
    check_eq({tag, "_run_after_start"}, core_run, 0);
    check_eq({tag, "_err_after_start"}, error, 0);

    for (int i = 0; i < nwords; i++) begin
      w = stim_w[i];
      send_byte(w[15:8], maxgap);
      if (i == inj_word) begin
        in_valid = 1'b0;
        start    = 1'b1;
        length   = AW'($urandom);
        @(negedge clock);
        start    = 1'b0;
        check_eq({tag, "_busy_after_ignored_start"}, busy, 1);
      end
      send_byte(w[7:0], maxgap);
    end
    send_byte(sent, maxgap);
    in_valid = 1'b0;
    repeat (3) @(negedge clock);

    check_eq({tag, "_nwrites"}, q_addr.size(), nwords);
    for (int i = 0; i < nwords && i < q_addr.size(); i++) begin
      check_eq({tag, "_addr"}, q_addr[i], i);
      check_eq({tag, "_data"}, q_data[i], stim_w[i]);
    end
    check_eq({tag, "_done_cnt"}, done_cnt, good ? 1 : 0);
    check_eq({tag, "_core_run"}, core_run, good ? 1 : 0);
    check_eq({tag, "_error"}, error, good ? 0 : 1);
    check_eq({tag, "_busy_end"}, busy, 0);
    if (timing) begin
      check_eq({tag, "_done_latency"}, done_cyc - s_cyc, 2 * nwords + 1);
      nspace = 0;
      for (int i = 1; i < q_cyc.size(); i++) if (q_cyc[i] - q_cyc[i-1] != 2) nspace++;
      check_eq({tag, "_write_spacing"}, nspace, 0);
    end
  endtask

  task automatic fill_random(input int n);
    stim_w.delete();
    for (int i = 0; i < n; i++) stim_w.push_back(16'($urandom));
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    bit          bad;
    logic [15:0] saved[$];

    #3;
    check_eq("reset_outputs", {in_ready, wr_en, wr_addr, wr_data, busy, done, error, core_run},
             0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_eq("idle_ready", in_ready, 0);

    stim_w.delete();
    stim_w.push_back(16'h1234);
    run_load("min", 1, 1'b0, 8'h00, 0, -1, 1'b1);

    fill_random(32);
    run_load("full", 32, 1'b0, 8'h00, 0, -1, 1'b1);

    stim_w.delete();
    stim_w.push_back(16'hA1B2);
    stim_w.push_back(16'hC3D4);
    run_load("badcs", 2, 1'b1, 8'h00, 0, -1, 1'b0);

    fill_random(3);
    saved = stim_w;
    run_load("nogap", 3, 1'b0, 8'h00, 0, -1, 1'b0);
    stim_w = saved;
    run_load("stall", 3, 1'b0, 8'h00, 5, -1, 1'b0);

    fill_random(3);
    run_load("busy_start", 3, 1'b0, 8'h00, 0, 1, 1'b0);

    fill_random(4);
    run_load("restart_from_run", 4, 1'b0, 8'h00, 1, -1, 1'b0);

    for (int t = 0; t < 8; t++) begin
      n   = int'($urandom_range(32, 1));
      bad = ($urandom_range(2, 0) == 0);
      fill_random(n);
      run_load("rand", n, bad, 8'($urandom), int'($urandom_range(3, 0)), -1, 1'b0);
    end

    // Reset after the high byte of word 2.
    fill_random(3);
    q_addr.delete();
    q_data.delete();
    q_cyc.delete();
    do_start(AW'(3));
    for (int i = 0; i < 2; i++) begin
      send_byte(stim_w[i][15:8], 0);
      send_byte(stim_w[i][7:0], 0);
    end
    send_byte(stim_w[2][15:8], 0);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("midreset_outputs",
             {in_ready, wr_en, wr_addr, wr_data, busy, done, error, core_run}, 0);
    check_eq("midreset_nwrites", q_addr.size(), 2);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("midreset_idle_busy", busy, 0);
    check_eq("midreset_idle_run", core_run, 0);
    check_eq("midreset_no_word2", q_addr.size(), 2);

    check_eq("no_back_to_back_writes", b2b_cnt, 0);
    check_eq("ready_matches_busy", rdy_viol, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Program loader for the autoencoder core's instruction memory. It accepts a byte stream over a valid/ready handshake and assembles the bytes into 16-bit instructions, each laid out as opcode[15:12] and three 4-bit fields. Each instruction is written sequentially into the instruction memory write port. A trailing XOR checksum byte validates the stream. The block holds the core (program counter and control unit) stopped until a load has completed with a good checksum, then asserts `core_run`.

## Interface
- `ADDR_WIDTH`, default 5: instruction memory address width; matches the 5-bit program counter.
- `DEPTH`, default 32: number of instruction words; equals 2^ADDR_WIDTH.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a load; sampled only in IDLE, RUN, ERR.
- `length`  in  5  words to load, captured on the accepted `start`; 0 means 32.
- `in_valid`  in  1  `in_data` holds a byte.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `wr_en`  out  1  instruction memory write strobe, one cycle per word.
- `wr_addr`  out  ADDR_WIDTH  write address.
- `wr_data`  out  16  instruction word.
- `busy`  out  1  high while a load is in progress (HI, LO, CHECK).
- `done`  out  1  one-cycle pulse on a successful load.
- `error`  out  1  sticky flag for a checksum mismatch.
- `core_run`  out  1  releases the core; high only in RUN.

## Operation
- States: IDLE, HI, LO, CHECK, RUN, ERR.
- A byte transfer occurs on a rising edge where `in_valid & in_ready` = 1. `in_ready` = 1 exactly in HI, LO and CHECK. It is a function of state only, never of `in_valid`.
- IDLE/RUN/ERR + `start` → HI. On that edge:
  - word count := `length` (0 → 32);
  - word index := 0;
  - running checksum := 0x00;
  - `error` := 0 and `core_run` := 0.
- HI + transfer → LO. The byte is latched as `wr_data[15:8]` (opcode and field 1) and XORed into the checksum.
- LO + transfer → the low byte is XORed into the checksum, and on the same edge:
  - `wr_en` := 1, `wr_addr` := word index, `wr_data` := {hi, lo};
  - word index increments;
  - next state is CHECK if this was the last word, otherwise HI.
- CHECK + transfer: byte equal to the running checksum → RUN with a `done` pulse; otherwise → ERR with `error` := 1.
- RUN: `core_run` = 1 and held until the next `start` or reset.
- ERR: `error` = 1 and `core_run` = 0, held until the next `start` or reset.
- `start` in HI, LO or CHECK is ignored. There is no abort; the only abort is reset.
- Memory contents are never cleared by this block. A failed load leaves any partially written words in memory, and `core_run` stays low.
- Word index is ADDR_WIDTH bits. A 32-word load writes addresses 0..31 and never wraps within a load.

## Timing
- Reset (async assert, sync-released by the system): state IDLE; `in_ready`, `wr_en`, `busy`, `done`, `error`, `core_run` = 0; `wr_addr` = 0; `wr_data` = 0x0000.
- Reset mid-load: return to IDLE immediately. A word whose low byte has not yet been accepted is not written.
- `wr_en` is registered: it is high for exactly the one cycle after the low-byte edge and never back-to-back. The minimum spacing between writes is 2 cycles.
- `wr_addr` and `wr_data` are valid whenever `wr_en` = 1 and hold until the next write.
- Maximum throughput is one byte per cycle with `in_valid` held high. A full 32-word load takes 65 transfer cycles after the `start` edge.
- `done` and `core_run` rise on the edge that accepts the checksum byte; `done` falls on the following edge.
- Gaps in `in_valid` stall the FSM in place. There is no timeout.

## Test plan
- Minimal load: `length`=1, then bytes 0x12, 0x34, 0x26 → one `wr_en` with addr 0, data 0x1234; `done` pulses once; `core_run`=1; `error`=0.
- Full load: `length`=0, then 64 bytes back-to-back with `in_valid` held high, followed by the correct checksum → 32 writes at addresses 0..31 spaced 2 cycles apart; `done` occurs 65 transfers after `start`; no address wrap.
- Bad checksum: `length`=2, words 0xA1B2 and 0xC3D4, then checksum 0x00 (correct value is 0x04) → both words written; `error`=1; `core_run`=0; a subsequent `start` clears `error`.
- Stalls: `length`=3 with random `in_valid` gaps of 0–5 cycles → the write sequence and data are identical to the gap-free run; `in_ready` never depends on `in_valid`.
- `start` while busy: assert `start` during LO of word 1 → ignored; the load completes normally; `start` in RUN drops `core_run` and restarts.
- Reset mid-load: drop `reset_n` after the high byte of word 2 → all outputs 0 immediately; no write for word 2; state IDLE after release.
